// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: controller states and the
// register map / control bits of the interval-timer slave it drives.
package timer_sched_pkg;

   typedef enum logic [3:0] {
      StInitStop,
      StInitClr,
      StIdle,
      StArb,
      StWrPl,
      StWrPh,
      StWrCtrl,
      StWaitIrq,
      StWrStat,
      StWrStop,
      StDone
   } state_t;

   localparam logic [2:0] AddrStatus  = 3'd0;
   localparam logic [2:0] AddrControl = 3'd1;
   localparam logic [2:0] AddrPeriodL = 3'd2;
   localparam logic [2:0] AddrPeriodH = 3'd3;

   localparam logic [15:0] CtrlIto   = 16'h0001;
   localparam logic [15:0] CtrlStart = 16'h0004;
   localparam logic [15:0] CtrlStop  = 16'h0008;
   // One-shot run with interrupt; continuous bit left clear.
   localparam logic [15:0] CtrlRun   = CtrlStart | CtrlIto;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   localparam logic [IW:0] NVal = (IW+1)'(N);

   logic [IW:0] w_sum;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_sum   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_sum >= NVal) begin
            w_sum = w_sum - NVal;
         end
         if (!o_valid && i_req[w_sum[IW-1:0]]) begin
            o_valid               = 1'b1;
            o_gnt[w_sum[IW-1:0]]  = 1'b1;
            o_idx                 = w_sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// Shares one interval timer among NCLIENT requesters: grants round-robin,
// programs a one-shot period, waits for expiry or cancel, then signals done.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int unsigned NCLIENT = 4,
   parameter int unsigned PW      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NCLIENT-1:0]    req,
   input  logic [NCLIENT*PW-1:0] period,
   input  logic [NCLIENT-1:0]    cancel,
   output logic [NCLIENT-1:0]    done,
   output logic                  err,
   output logic                  busy,
   output logic [2:0]            tmr_address,
   output logic                  tmr_chipselect,
   output logic                  tmr_write_n,
   output logic [15:0]           tmr_writedata,
   input  logic                  tmr_irq
);

   localparam int unsigned IW = $clog2(NCLIENT);

   state_t              r_state, w_state_next;
   logic [IW-1:0]       r_ptr, r_gnt;
   logic [NCLIENT-1:0]  r_gnt_oh;
   logic [PW-1:0]       r_pm1;
   logic                r_err, r_mask;

   logic [NCLIENT-1:0]  w_req_eff, w_arb_gnt;
   logic [IW-1:0]       w_arb_idx;
   logic                w_arb_valid, w_short, w_cancel, w_wr;
   logic [PW-1:0]       w_per [NCLIENT];
   logic [PW-1:0]       w_per_sel;
   logic [31:0]         w_pm1_ext;

   for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_per
      assign w_per[gi] = period[gi*PW +: PW];
   end

   // The just-served client is hidden for one cycle so a late req drop is not re-granted.
   assign w_req_eff = req & ~(r_mask ? r_gnt_oh : '0);
   assign w_per_sel = w_per[w_arb_idx];
   assign w_short   = (w_per_sel < PW'(2));
   assign w_cancel  = |(cancel & r_gnt_oh);

   always_comb begin
      w_pm1_ext         = '0;
      w_pm1_ext[PW-1:0] = r_pm1;
   end

   rr_arbiter #(
      .N  (NCLIENT),
      .IW (IW)
   ) u_arb (
      .i_req   (w_req_eff),
      .i_ptr   (r_ptr),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StInitStop: w_state_next = StInitClr;
         StInitClr:  w_state_next = StIdle;
         StIdle:     if (|w_req_eff) w_state_next = StArb;
         StArb: begin
            if (!w_arb_valid)  w_state_next = StIdle;
            else if (w_short)  w_state_next = StDone;
            else               w_state_next = StWrPl;
         end
         StWrPl:     w_state_next = StWrPh;
         StWrPh:     w_state_next = StWrCtrl;
         StWrCtrl:   w_state_next = StWaitIrq;
         StWaitIrq: begin
            if (w_cancel)      w_state_next = StWrStop;
            else if (tmr_irq)  w_state_next = StWrStat;
         end
         StWrStop:   w_state_next = StWrStat;
         StWrStat:   w_state_next = StDone;
         StDone:     w_state_next = StIdle;
         default:    w_state_next = StInitStop;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StInitStop;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_gnt_oh <= '0;
         r_pm1    <= '0;
         r_err    <= 1'b0;
         r_mask   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_mask  <= (r_state == StDone);
         if (r_state == StArb && w_arb_valid) begin
            r_gnt    <= w_arb_idx;
            r_gnt_oh <= w_arb_gnt;
            r_pm1    <= w_per_sel - PW'(1);
            r_err    <= w_short;
         end
         if (r_state == StWaitIrq && w_cancel) begin
            r_err <= 1'b1;
         end
         if (r_state == StDone) begin
            r_ptr <= (r_gnt == IW'(NCLIENT-1)) ? '0 : r_gnt + 1'b1;
         end
      end
   end

   // Outputs are gated by reset so the bus stays quiet while reset is held.
   always_comb begin
      w_wr          = 1'b0;
      tmr_address   = '0;
      tmr_writedata = '0;
      done          = '0;
      err           = 1'b0;
      busy          = 1'b1;
      if (!reset) begin
         unique case (r_state)
            StInitStop: begin w_wr = 1'b1; tmr_address = AddrControl; tmr_writedata = CtrlStop; end
            StInitClr:  begin w_wr = 1'b1; tmr_address = AddrStatus; end
            StIdle:     busy = 1'b0;
            StWrPl:     begin w_wr = 1'b1; tmr_address = AddrPeriodL; tmr_writedata = w_pm1_ext[15:0]; end
            StWrPh:     begin w_wr = 1'b1; tmr_address = AddrPeriodH; tmr_writedata = w_pm1_ext[31:16]; end
            StWrCtrl:   begin w_wr = 1'b1; tmr_address = AddrControl; tmr_writedata = CtrlRun; end
            StWrStop:   begin w_wr = 1'b1; tmr_address = AddrControl; tmr_writedata = CtrlStop; end
            StWrStat:   begin w_wr = 1'b1; tmr_address = AddrStatus; end
            StDone: begin
               done = r_gnt_oh;
               err  = r_err;
            end
            default: ;
         endcase
      end
      tmr_chipselect = w_wr;
      tmr_write_n    = ~w_wr;
   end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: logs bus writes and done pulses, models the
// timer's expiry interrupt, and compares against hand-computed expectations.
module tb_timer_sched;

   localparam int unsigned NC = 4;
   localparam int unsigned PW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [NC-1:0]     req, cancel, done;
   logic [NC*PW-1:0]  period;
   logic              err, busy, tmr_chipselect, tmr_write_n, tmr_irq;
   logic [2:0]        tmr_address;
   logic [15:0]       tmr_writedata;

   always #5 clk = ~clk;

   timer_sched #(
      .NCLIENT (NC),
      .PW      (PW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .period         (period),
      .cancel         (cancel),
      .done           (done),
      .err            (err),
      .busy           (busy),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq)
   );

   typedef struct {int unsigned c; logic [2:0] a; logic [15:0] d;} wr_t;
   typedef struct {int unsigned c; logic [3:0] v; logic e;} dn_t;

   wr_t         wr_q[$];
   dn_t         dn_q[$];
   wr_t         mon_wr;
   dn_t         mon_dn;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   logic        use_model = 1'b1;
   logic        irq_manual = 1'b0;
   logic        model_irq = 1'b0;
   logic        irq_en = 1'b0;
   int unsigned irq_at = 0;
   logic [15:0] m_pl = '0;
   logic [15:0] m_ph = '0;

   assign tmr_irq = use_model ? model_irq : irq_manual;

   always @(posedge clk) cyc <= cyc + 1;

   // Timer model: irq rises P+2 cycles after the control write starts it.
   always @(posedge clk) begin
      #1;
      model_irq = irq_en && (cyc >= irq_at);
   end

   always @(negedge clk) begin
      if (reset) irq_en = 1'b0;
      if (tmr_chipselect && !tmr_write_n) begin
         mon_wr.c = cyc;
         mon_wr.a = tmr_address;
         mon_wr.d = tmr_writedata;
         wr_q.push_back(mon_wr);
         if (tmr_address == 3'd2) m_pl = tmr_writedata;
         if (tmr_address == 3'd3) m_ph = tmr_writedata;
         if (tmr_address == 3'd1 && tmr_writedata == 16'h0005) begin
            irq_at = cyc + {m_ph, m_pl} + 3;
            irq_en = 1'b1;
         end
         if ((tmr_address == 3'd1 && tmr_writedata == 16'h0008) || tmr_address == 3'd0) begin
            irq_en = 1'b0;
         end
      end
      if (|done) begin
         mon_dn.c = cyc;
         mon_dn.v = done;
         mon_dn.e = err;
         dn_q.push_back(mon_dn);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [2:0] a,
                           input logic [15:0] d, input int unsigned c, input bit use_c);
      if (wr_q.size() <= idx) begin
         check_eq({tag, "_present"}, wr_q.size(), idx + 1);
      end else begin
         check_eq({tag, "_addr"}, wr_q[idx].a, a);
         check_eq({tag, "_data"}, wr_q[idx].d, d);
         if (use_c) check_eq({tag, "_cyc"}, wr_q[idx].c, c);
      end
   endtask

   task automatic check_done(input string tag, input logic [3:0] v, input logic e,
                             input int unsigned c, input bit use_c);
      if (dn_q.size() == 0) begin
         check_eq({tag, "_present"}, dn_q.size(), 1);
      end else begin
         check_eq({tag, "_vec"}, dn_q[0].v, v);
         check_eq({tag, "_err"}, dn_q[0].e, e);
         if (use_c) check_eq({tag, "_cyc"}, dn_q[0].c, c);
      end
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (wr_q.size() < n && k < budget) begin
         tick;
         k++;
      end
      check_eq("wait_writes", wr_q.size() >= n, 1);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (dn_q.size() == 0 && k < budget) begin
         tick;
         k++;
      end
      check_eq("wait_done", dn_q.size() > 0, 1);
   endtask

   task automatic clear_logs;
      wr_q.delete();
      dn_q.delete();
   endtask

   int unsigned rr_p [4] = '{3, 4, 2, 6};
   int unsigned t, c, r;

   initial begin
      reset  = 1'b1;
      req    = '0;
      cancel = '0;
      period = '0;
      repeat (3) tick;
      check_eq("rst_cs", tmr_chipselect, 1'b0);
      check_eq("rst_wn", tmr_write_n, 1'b1);
      check_eq("rst_addr", tmr_address, 3'd0);
      check_eq("rst_wdata", tmr_writedata, 16'h0);
      check_eq("rst_busy", busy, 1'b1);
      check_eq("rst_done", done, 4'h0);
      check_eq("rst_err", err, 1'b0);

      // Init write pair, then idle on the third cycle.
      reset = 1'b0;
      t = cyc;
      tick;
      tick;
      check_eq("init_busy", busy, 1'b0);
      check_eq("init_nwr", wr_q.size(), 2);
      check_wr("init_stop", 0, 3'd1, 16'h0008, t, 1);
      check_wr("init_clr", 1, 3'd0, 16'h0000, t + 1, 1);
      clear_logs;

      // All four clients request; expect one grant each in order 0..3.
      for (int i = 0; i < 4; i++) period[i*PW +: PW] = rr_p[i];
      req = 4'hF;
      for (int i = 0; i < 4; i++) begin
         wait_done(200);
         if (dn_q.size() > 0) req = req & ~dn_q[0].v;
         check_done($sformatf("rr%0d", i), 4'(1 << i), 1'b0, 0, 0);
         check_eq("rr_nwr", wr_q.size(), 4);
         check_wr("rr_pl", 0, 3'd2, 16'(rr_p[i] - 1), 0, 0);
         check_wr("rr_ph", 1, 3'd3, 16'h0000, 0, 0);
         check_wr("rr_ctrl", 2, 3'd1, 16'h0005, 0, 0);
         check_wr("rr_stat", 3, 3'd0, 16'h0000, 0, 0);
         if (wr_q.size() > 2 && dn_q.size() > 0) begin
            check_eq("rr_latency", dn_q[0].c - wr_q[2].c, rr_p[i] + 4);
         end
         clear_logs;
      end
      repeat (10) tick;
      check_eq("rr_once", dn_q.size(), 0);
      check_eq("rr_idle", busy, 1'b0);

      // Large period on client 1; expiry driven by hand.
      use_model  = 1'b0;
      irq_manual = 1'b0;
      period[1*PW +: PW] = 32'h0001_86A0;
      req = 4'b0010;
      t = cyc;
      wait_writes(3, 50);
      check_wr("big_pl", 0, 3'd2, 16'h869F, t + 2, 1);
      check_wr("big_ph", 1, 3'd3, 16'h0001, t + 3, 1);
      check_wr("big_ctrl", 2, 3'd1, 16'h0005, t + 4, 1);
      repeat (20) tick;
      check_eq("big_no_early", dn_q.size(), 0);
      check_eq("big_busy", busy, 1'b1);
      irq_manual = 1'b1;
      c = cyc;
      wait_done(20);
      check_wr("big_stat", 3, 3'd0, 16'h0000, c + 1, 1);
      check_done("big_done", 4'b0010, 1'b0, c + 2, 1);
      // Client keeps req high one extra cycle; it must not be re-granted.
      irq_manual = 1'b0;
      tick;
      req = '0;
      check_eq("mask_busy", busy, 1'b0);
      repeat (5) tick;
      check_eq("mask_nowr", wr_q.size(), 4);
      clear_logs;

      // Periods below 2 are rejected without touching the timer.
      use_model = 1'b1;
      period[2*PW +: PW] = 32'd1;
      req = 4'b0100;
      t = cyc;
      wait_done(20);
      check_done("short", 4'b0100, 1'b1, t + 2, 1);
      check_eq("short_nocs", wr_q.size(), 0);
      req = '0;
      tick;
      clear_logs;
      period[0 +: PW] = 32'd0;
      req = 4'b0001;
      t = cyc;
      wait_done(20);
      check_done("zero", 4'b0001, 1'b1, t + 2, 1);
      check_eq("zero_nocs", wr_q.size(), 0);
      req = '0;
      repeat (2) tick;
      clear_logs;

      // Cancel on the 50th cycle of the wait.
      period[0 +: PW] = 32'd1000;
      req = 4'b0001;
      wait_writes(3, 50);
      check_wr("can_ctrl", 2, 3'd1, 16'h0005, 0, 0);
      c = (wr_q.size() > 2) ? wr_q[2].c : cyc;
      while (cyc < c + 50) tick;
      cancel = 4'b0001;
      wait_done(20);
      check_wr("can_stop", 3, 3'd1, 16'h0008, c + 51, 1);
      check_wr("can_stat", 4, 3'd0, 16'h0000, c + 52, 1);
      check_done("can_done", 4'b0001, 1'b1, c + 53, 1);
      cancel = '0;
      req = '0;
      repeat (2) tick;
      clear_logs;

      // Cancel and irq together: cancel wins.
      use_model = 1'b0;
      period[0 +: PW] = 32'd20;
      req = 4'b0001;
      wait_writes(3, 50);
      c = (wr_q.size() > 2) ? wr_q[2].c : cyc;
      while (cyc < c + 5) tick;
      cancel = 4'b0001;
      irq_manual = 1'b1;
      wait_done(20);
      check_wr("both_stop", 3, 3'd1, 16'h0008, c + 6, 1);
      check_wr("both_stat", 4, 3'd0, 16'h0000, c + 7, 1);
      check_done("both_done", 4'b0001, 1'b1, c + 8, 1);
      cancel = '0;
      irq_manual = 1'b0;
      req = '0;
      repeat (2) tick;
      clear_logs;

      // Reset mid-wait abandons the grant.
      use_model = 1'b1;
      period[3*PW +: PW] = 32'd500;
      req = 4'b1000;
      wait_writes(3, 50);
      repeat (10) tick;
      reset = 1'b1;
      req = '0;
      repeat (2) tick;
      check_eq("rmid_nodone", dn_q.size(), 0);
      check_eq("rmid_nowr", wr_q.size(), 3);
      clear_logs;
      reset = 1'b0;
      r = cyc;
      tick;
      tick;
      check_wr("rmid_stop", 0, 3'd1, 16'h0008, r, 1);
      check_wr("rmid_clr", 1, 3'd0, 16'h0000, r + 1, 1);
      repeat (20) tick;
      check_eq("rmid_quiet", dn_q.size(), 0);
      clear_logs;
      period[2*PW +: PW] = 32'd4;
      req = 4'b0100;
      wait_done(100);
      check_done("rmid_new", 4'b0100, 1'b0, 0, 0);
      if (wr_q.size() > 2 && dn_q.size() > 0) begin
         check_eq("rmid_latency", dn_q[0].c - wr_q[2].c, 32'd8);
      end
      req = '0;
      repeat (2) tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 SHALL have parameter NCLIENT, default 4, number of requesting clients (2..8).
REQ-002 SHALL have parameter PW, default 32, width of a requested period in clock cycles.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NCLIENT  per-client level request; client holds it high until its done pulse.
REQ-006 SHALL have port period  input  NCLIENT*PW  per-client period, slice i at [i*PW +: PW]; stable while req[i] is high.
REQ-007 SHALL have port cancel  input  NCLIENT  per-client abort; honoured only for the granted client.
REQ-008 SHALL have port done  output  NCLIENT  one-cycle completion pulse to the granted client.
REQ-009 SHALL have port err  output  1  valid with done: 1 = rejected or cancelled, 0 = normal expiry.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have ports tmr_address output 3, tmr_chipselect output 1, tmr_write_n output 1, tmr_writedata output 16 for the timer slave port.
REQ-012 SHALL have port tmr_irq  input  1  timer interrupt, level, registered in the timer.

Function
REQ-013 SHALL implement states INIT_STOP, INIT_CLR, IDLE, ARB, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_STAT, WR_STOP, DONE.
REQ-014 SHALL spend exactly one cycle in each write state; in it, chipselect=1, write_n=0, plus the fixed address and data below. In all other states, chipselect=0, write_n=1, address=0, writedata=0.
REQ-015 INIT_STOP SHALL write addr 1, data 0x0008 (STOP); INIT_CLR SHALL write addr 0, data 0x0000; then go to IDLE.
REQ-016 IDLE SHALL go to ARB when any req bit is high; ARB SHALL grant round-robin, starting at the index after the last grantee (index 0 after reset).
REQ-017 ARB SHALL latch grant index g and P = period[g] in one cycle.
REQ-018 If P < 2, ARB SHALL go straight to DONE with err=1, with no timer access.
REQ-019 Otherwise the sequence SHALL be: WR_PL (addr 2, data (P-1)[15:0]); WR_PH (addr 3, data (P-1)[31:16], zero-extended when PW<32); WR_CTRL (addr 1, data 0x0005 = START|ITO, continuous=0).
REQ-020 WAIT_IRQ SHALL hold until tmr_irq=1, then go to WR_STAT with err flag 0.
REQ-021 If cancel[g]=1 in WAIT_IRQ, the block SHALL go to WR_STOP (addr 1, data 0x0008), then WR_STAT, with err flag 1. If irq and cancel are high in the same cycle, cancel SHALL win.
REQ-022 WR_STAT SHALL write addr 0, data 0x0000 to clear the timeout, then go to DONE.
REQ-023 DONE SHALL pulse done[g] for one cycle, drive err for that cycle, set the round-robin pointer to g+1 mod NCLIENT, and return to IDLE.
REQ-024 req[g] SHALL be ignored for one cycle after DONE, so a client dropping req on the following cycle is not re-granted.
REQ-025 Expiry latency: tmr_irq is high P+2 cycles after the WR_CTRL cycle (P-1 down to 0, plus the timer's registered irq). done SHALL pulse 2 cycles after irq is first sampled high.

Reset
REQ-026 Reset SHALL force state INIT_STOP, round-robin pointer 0, done=0, err=0, busy=1, chipselect=0, write_n=1, address=0, writedata=0.
REQ-027 Reset during any state, including mid-sequence, SHALL abandon the grant without a done pulse; INIT_STOP/INIT_CLR then stop the timer and clear its status.

Structure
REQ-028 A shared package timer_sched_pkg SHALL hold the state enum, the timer register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3) and the control constants (ITO=0x1, START=0x4, STOP=0x8).
REQ-029 The round-robin arbiter SHALL be a sub-module rr_arbiter (inputs: req vector, pointer; output: one-hot grant plus index).

Verification
REQ-030 After reset release: expect addr1/0x0008 write, then addr0/0x0000 write, then busy=0 on the third cycle.
REQ-031 req[1]=1, period=0x0001_86A0: expect writes 2/0x869F, 3/0x0001, 1/0x0005; irq 100002 cycles after WR_CTRL; write 0/0x0000; done[1] with err=0.
REQ-032 req=4'b1111 held, each client dropping req after its done: expect grants in order 0,1,2,3, and each client granted exactly once.
REQ-033 req[2]=1, period=1: expect done[2]=1 and err=1 two cycles after req, with chipselect never asserted.
REQ-034 req[0]=1, period=1000, cancel[0]=1 at cycle 50 of WAIT_IRQ: expect 1/0x0008 write, then 0/0x0000 write, then done[0] with err=1. Also cancel and irq in the same cycle: same result.
REQ-035 Reset asserted during WAIT_IRQ: expect no done pulse, then the INIT write pair, then normal service of a new request.
